// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add multiplier, one partial product per cycle.
// Ports: Clk, Rst (async active-low), Start, Abort, Signed, A, B -> Produto, Busy, Finalizado.
module multiplicador_seq #(
   parameter int WIDTH = 8
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic               Abort,
   input  logic               Signed,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] Produto,
   output logic               Busy,
   output logic               Finalizado
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int PW = 2 * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic             r_neg;
   logic [CW-1:0]    r_cnt;
   logic [PW-1:0]    r_acc;
   logic [PW-1:0]    r_prod;

   logic             w_start;
   logic             w_last;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [PW-1:0]    w_addend;
   logic [PW-1:0]    w_sum;

   // Magnitudes: the most negative value maps onto its unsigned twin.
   always_comb begin
      w_mag_a = A;
      w_mag_b = B;
      if (Signed && A[WIDTH-1]) w_mag_a = ~A + WIDTH'(1);
      if (Signed && B[WIDTH-1]) w_mag_b = ~B + WIDTH'(1);
   end

   assign w_start  = Start && (r_state != BUSY);
   assign w_last   = (r_cnt == LAST);
   assign w_addend = r_mplier[0] ? (PW'(r_mcand) << r_cnt) : '0;
   assign w_sum    = r_acc + w_addend;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // Abort outranks completion on the final busy edge.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (Start) w_next = BUSY;
         BUSY: begin
            if (Abort)       w_next = IDLE;
            else if (w_last) w_next = DONE;
         end
         DONE: w_next = Start ? BUSY : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_prod   <= '0;
      end else if (w_start) begin
         r_mcand  <= w_mag_a;
         r_mplier <= w_mag_b;
         r_neg    <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
         r_cnt    <= '0;
         r_acc    <= '0;
      end else if (r_state == BUSY && !Abort) begin
         r_acc    <= w_sum;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) r_prod <= r_neg ? (~w_sum + PW'(1)) : w_sum;
      end
   end

   assign Produto    = r_prod;
   assign Busy       = (r_state == BUSY);
   assign Finalizado = (r_state == DONE);

endmodule
